// File: rtl/timerio_pkg.sv
// Shared constants for the timerio peripheral: register map, CTRL/STAT bit positions
// and reset defaults.
package timerio_pkg;

    localparam logic [2:0] TMR_CTRL  = 3'd0;
    localparam logic [2:0] TMR_STAT  = 3'd1;
    localparam logic [2:0] TMR_CNT_H = 3'd2;
    localparam logic [2:0] TMR_CNT_L = 3'd3;
    localparam logic [2:0] TMR_RLD_H = 3'd4;
    localparam logic [2:0] TMR_RLD_L = 3'd5;
    localparam logic [2:0] TMR_CAP_H = 3'd6;
    localparam logic [2:0] TMR_CAP_L = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PSEL_LO = 3;
    localparam int CTRL_PSEL_HI = 5;
    localparam int CTRL_CIE     = 6;

    localparam int STAT_OVF = 0;
    localparam int STAT_CAP = 1;

    localparam int          TMR_PRESC_W      = 8;
    localparam logic [15:0] TMR_RESET_RELOAD = 16'hFFFF;

endpackage

// File: rtl/timerio_presc.sv
// Prescaler for timerio: free-running counter held at zero by clr; tick fires when the
// low sel bits are all ones, giving a divide ratio of 2^sel (sel=0 ticks every cycle).
module timerio_presc
    import timerio_pkg::*;
#(
    parameter int PRESC_W = TMR_PRESC_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [2:0] sel,
    output logic       tick
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] mask;
    int                 sel_lim;

    // Selections beyond the counter width saturate to the widest divide.
    always_comb begin
        sel_lim = (int'(sel) >= PRESC_W) ? PRESC_W - 1 : int'(sel);
        mask    = '0;
        for (int i = 0; i < PRESC_W; i++) begin
            mask[i] = (i < sel_lim);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    assign tick = ~clr & ((presc & mask) == mask);

endmodule

// File: rtl/timerio.sv
// 16-bit programmable down-counter on the 6801 bus with atomic 8-bit register access.
// Optional input capture is built when TIMERIO_CAPTURE_EN is defined.
module timerio
    import timerio_pkg::*;
#(
    parameter int          PRESC_W      = TMR_PRESC_W,
    parameter logic [15:0] RESET_RELOAD = TMR_RESET_RELOAD
) (
    input  logic       clk,
    input  logic       rst,
    output logic       irq,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic       cap_in
);

    logic        en;
    logic        ar;
    logic        ie;
    logic        cie;
    logic [2:0]  psel;
    logic        ovf;
    logic        cap_flag;
    logic [15:0] cnt;
    logic [15:0] rld;
    logic [7:0]  hi_buf;
    logic [7:0]  lo_buf;
    logic        tick;
    logic        expire;

    logic wr;
    logic rd;
    logic wr_ctrl;
    logic wr_stat;
    logic wr_rld_h;
    logic wr_rld_l;
    logic rd_cnt_h;

    assign wr       = cs & ~rw;
    assign rd       = cs & rw;
    assign wr_ctrl  = wr && (AD == TMR_CTRL);
    assign wr_stat  = wr && (AD == TMR_STAT);
    assign wr_rld_h = wr && (AD == TMR_RLD_H);
    assign wr_rld_l = wr && (AD == TMR_RLD_L);
    assign rd_cnt_h = rd && (AD == TMR_CNT_H);

    timerio_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (~en),
        .sel  (psel),
        .tick (tick)
    );

    assign expire = tick && (cnt == 16'h0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en     <= 1'b0;
            ar     <= 1'b0;
            ie     <= 1'b0;
            psel   <= 3'd0;
            ovf    <= 1'b0;
            cnt    <= RESET_RELOAD;
            rld    <= RESET_RELOAD;
            hi_buf <= 8'h00;
            lo_buf <= 8'h00;
        end else begin
            // A CPU write to CTRL overrides the one-shot self-disable on the same edge.
            if (wr_ctrl) begin
                en   <= DI[CTRL_EN];
                ar   <= DI[CTRL_AR];
                ie   <= DI[CTRL_IE];
                psel <= DI[CTRL_PSEL_HI:CTRL_PSEL_LO];
            end else if (expire && !ar) begin
                en <= 1'b0;
            end

            // Hardware set wins over a simultaneous write-1-to-clear.
            ovf <= (ovf & ~(wr_stat & DI[STAT_OVF])) | expire;

            if (wr_rld_h) hi_buf <= DI;
            if (rd_cnt_h) lo_buf <= cnt[7:0];
            if (wr_rld_l) rld    <= {hi_buf, DI};

            if (tick) begin
                if (cnt != 16'h0000) begin
                    cnt <= cnt - 16'd1;
                end else if (ar) begin
                    cnt <= rld;
                end
            end else if (wr_rld_l && !en) begin
                cnt <= {hi_buf, DI};
            end
        end
    end

`ifdef TIMERIO_CAPTURE_EN
    logic [2:0]  cap_sync;
    logic [15:0] cap_val;
    logic [7:0]  cap_lo_buf;
    logic        cap_rise;
    logic        rd_cap_h;

    assign cap_rise = cap_sync[1] & ~cap_sync[2];
    assign rd_cap_h = rd && (AD == TMR_CAP_H);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_sync   <= 3'b000;
            cap_val    <= 16'h0000;
            cap_lo_buf <= 8'h00;
            cap_flag   <= 1'b0;
            cie        <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], cap_in};
            if (cap_rise) cap_val    <= cnt;
            if (rd_cap_h) cap_lo_buf <= cap_val[7:0];
            if (wr_ctrl)  cie        <= DI[CTRL_CIE];
            cap_flag <= (cap_flag & ~(wr_stat & DI[STAT_CAP])) | cap_rise;
        end
    end
`else
    logic unused_cap_in;

    assign unused_cap_in = cap_in;
    assign cap_flag      = 1'b0;
    assign cie           = 1'b0;
`endif

    assign irq = (ovf & ie) | (cap_flag & cie);

    always_comb begin
        DO = 8'h00;
        case (AD)
            TMR_CTRL:  DO = {1'b0, cie, psel, ie, ar, en};
            TMR_STAT:  DO = {6'b000000, cap_flag, ovf};
            TMR_CNT_H: DO = cnt[15:8];
            TMR_CNT_L: DO = lo_buf;
            TMR_RLD_H: DO = rld[15:8];
            TMR_RLD_L: DO = rld[7:0];
`ifdef TIMERIO_CAPTURE_EN
            TMR_CAP_H: DO = cap_val[15:8];
            TMR_CAP_L: DO = cap_lo_buf;
`endif
            default:   DO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_timerio.sv
// Directed bench for timerio with hand-computed expectations; capture scenario is
// compiled in when TIMERIO_CAPTURE_EN is defined.
module tb_timerio;
    import timerio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       cap_in;

    int checks = 0;
    int errors = 0;

    timerio dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .AD     (AD),
        .DI     (DI),
        .DO     (DO),
        .rw     (rw),
        .cs     (cs),
        .cap_in (cap_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus tasks start at a negedge; the access takes effect on the following posedge.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        chk(tag, {8'h00, d}, {8'h00, exp});
    endtask

    logic [7:0] rst_exp [8];

    initial begin
        rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00; cap_in = 1'b0;
        rst_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset values
        chk("rst_irq", {15'd0, irq}, 16'd0);
        rd_chk("rst_lo_buf", TMR_CNT_L, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("rst_reg%0d", i), 3'(i), rst_exp[i]);
        end

        // Periodic, PSEL=0: OVF 4 cycles after enable, reload, W1C
        bus_write(TMR_RLD_H, 8'h00);
        bus_write(TMR_RLD_L, 8'h03);
        bus_write(TMR_CTRL, 8'h07);
        repeat (3) @(negedge clk);
        chk("per_irq_pre", {15'd0, irq}, 16'd0);
        @(negedge clk);
        chk("per_irq_ovf", {15'd0, irq}, 16'd1);
        rd_chk("per_cnt_h", TMR_CNT_H, 8'h00);
        rd_chk("per_cnt_l", TMR_CNT_L, 8'h03);
        rd_chk("per_stat", TMR_STAT, 8'h01);
        bus_write(TMR_CTRL, 8'h06);
        chk("per_irq_hold", {15'd0, irq}, 16'd1);
        bus_write(TMR_STAT, 8'h01);
        chk("per_irq_w1c", {15'd0, irq}, 16'd0);
        rd_chk("per_stat_clr", TMR_STAT, 8'h00);

        // One-shot
        bus_write(TMR_RLD_H, 8'h00);
        bus_write(TMR_RLD_L, 8'h02);
        bus_write(TMR_CTRL, 8'h05);
        repeat (2) @(negedge clk);
        chk("os_irq_pre", {15'd0, irq}, 16'd0);
        @(negedge clk);
        chk("os_irq_ovf", {15'd0, irq}, 16'd1);
        repeat (20) @(negedge clk);
        rd_chk("os_ctrl", TMR_CTRL, 8'h04);
        rd_chk("os_cnt_h", TMR_CNT_H, 8'h00);
        rd_chk("os_cnt_l", TMR_CNT_L, 8'h00);
        rd_chk("os_stat", TMR_STAT, 8'h01);
        bus_write(TMR_STAT, 8'h01);
        chk("os_irq_clr", {15'd0, irq}, 16'd0);

        // Prescale PSEL=3, RLD=1: OVF exactly 16 cycles after enable
        bus_write(TMR_RLD_H, 8'h00);
        bus_write(TMR_RLD_L, 8'h01);
        bus_write(TMR_CTRL, 8'h1D);
        repeat (15) @(negedge clk);
        chk("psc_irq_pre", {15'd0, irq}, 16'd0);
        @(negedge clk);
        chk("psc_irq_ovf", {15'd0, irq}, 16'd1);
        rd_chk("psc_ctrl", TMR_CTRL, 8'h1C);
        rd_chk("psc_cnt_h", TMR_CNT_H, 8'h00);
        bus_write(TMR_STAT, 8'h01);

        // Atomic 16-bit read
        bus_write(TMR_RLD_H, 8'h12);
        bus_write(TMR_RLD_L, 8'hFF);
        bus_write(TMR_CTRL, 8'h01);
        rd_chk("atom_h1", TMR_CNT_H, 8'h12);
        repeat (3) @(negedge clk);
        rd_chk("atom_l1", TMR_CNT_L, 8'hFF);
        rd_chk("atom_h2", TMR_CNT_H, 8'h12);
        rd_chk("atom_l2", TMR_CNT_L, 8'hFA);
        bus_write(TMR_CTRL, 8'h00);
        bus_write(TMR_CNT_H, 8'h55);
        rd_chk("cnt_wr_ign_h", TMR_CNT_H, 8'h12);
        rd_chk("cnt_wr_ign_l", TMR_CNT_L, 8'hF7);

        // OVF set and W1C on the same edge: set wins
        bus_write(TMR_RLD_H, 8'h00);
        bus_write(TMR_RLD_L, 8'h02);
        bus_write(TMR_CTRL, 8'h03);
        repeat (2) @(negedge clk);
        bus_write(TMR_STAT, 8'h01);
        rd_chk("w1c_collide", TMR_STAT, 8'h01);
        bus_write(TMR_CTRL, 8'h00);
        bus_write(TMR_STAT, 8'h01);
        rd_chk("w1c_after", TMR_STAT, 8'h00);

`ifdef TIMERIO_CAPTURE_EN
        bus_write(TMR_RLD_H, 8'h00);
        bus_write(TMR_RLD_L, 8'h50);
        bus_write(TMR_CTRL, 8'h41);
        repeat (16) @(negedge clk);
        cap_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("cap_irq", {15'd0, irq}, 16'd1);
        rd_chk("cap_h", TMR_CAP_H, 8'h00);
        rd_chk("cap_l", TMR_CAP_L, 8'h3E);
        rd_chk("cap_stat", TMR_STAT, 8'h02);
        bus_write(TMR_CTRL, 8'h00);
        cap_in = 1'b0;
        bus_write(TMR_STAT, 8'h02);
        chk("cap_irq_clr", {15'd0, irq}, 16'd0);
`else
        cap_in = 1'b1;
        repeat (4) @(negedge clk);
        rd_chk("nocap_stat", TMR_STAT, 8'h00);
        rd_chk("nocap_h", TMR_CAP_H, 8'h00);
        rd_chk("nocap_l", TMR_CAP_L, 8'h00);
        cap_in = 1'b0;
`endif

        // Reset asserted mid-count
        bus_write(TMR_RLD_H, 8'h00);
        bus_write(TMR_RLD_L, 8'h01);
        bus_write(TMR_CTRL, 8'h07);
        repeat (2) @(negedge clk);
        chk("mid_irq_pre", {15'd0, irq}, 16'd1);
        #2 rst = 1'b0;
        #1 chk("mid_irq_async", {15'd0, irq}, 16'd0);
        AD = TMR_CNT_H;
        #1 chk("mid_cnt_h_async", {8'h00, DO}, 16'h00FF);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("mid_cnt_h", TMR_CNT_H, 8'hFF);
        rd_chk("mid_cnt_l", TMR_CNT_L, 8'hFF);
        rd_chk("mid_ctrl", TMR_CTRL, 8'h00);
        rd_chk("mid_stat", TMR_STAT, 8'h00);
        rd_chk("mid_rld_l", TMR_RLD_L, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
